// File: rtl/oipuf_pkg.sv
// Shared definitions for the OIPUF64x4 evaluation controller.
//   - state_e     : sequencer FSM states
//   - TW_DEF/ST_DEF : default arbiter-chain count and stage count
//   - oipuf_clog2 : ceil(log2(v)) usable in constant expressions
package oipuf_pkg;

  localparam int TW_DEF = 4;
  localparam int ST_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic int oipuf_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oipuf_vote_acc.sv
// Per-chain vote accumulator (built only with MAJORITY_VOTE_EN).
// Counts ones over NVOTE samples and ANDs the core's stability flag.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clr_i       start of a new request: clear count, preset stable-AND
//   en_i        one evaluation sample this cycle
//   bit_i       sampled response bit
//   stable_i    sampled stability flag
//   maj_o       majority result (ones > NVOTE/2)
//   rel_o       all votes equal AND stable in every sample
import oipuf_pkg::*;

module oipuf_vote_acc #(
  parameter int NVOTE = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  input  logic stable_i,
  output logic maj_o,
  output logic rel_o
);

  localparam int OW = oipuf_clog2(NVOTE + 1);

  logic [OW-1:0] ones_q;
  logic          stab_and_q;
  logic          agree;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q     <= '0;
      stab_and_q <= 1'b0;
    end else if (clr_i) begin
      ones_q     <= '0;
      stab_and_q <= 1'b1;
    end else if (en_i) begin
      ones_q     <= ones_q + OW'(bit_i);
      stab_and_q <= stab_and_q & stable_i;
    end
  end

  // Once every vote is in, "all equal" is simply all-zeros or all-ones.
  assign agree = (ones_q == '0) || (ones_q == OW'(NVOTE));
  assign maj_o = ones_q > OW'(NVOTE / 2);
  assign rel_o = agree & stab_and_q;

endmodule

// File: rtl/oipuf_eval_ctrl.sv
// Evaluation sequencer for one OIPUF64x4 core.
// Accepts a challenge, drives it to the core, runs re-arm / trigger / settle
// windows, samples response and stability, and returns the result.
// Optional feature macro: MAJORITY_VOTE_EN (NVOTE evaluations, per-bit majority).
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   req_valid/req_ready/req_chal  challenge request handshake
//   puf_tig, puf_chal             trigger and registered challenge to the core
//   puf_resp, puf_stable_each     per-chain response / stability from the core
//   rsp_valid/rsp_ready           result handshake
//   rsp_resp, rsp_xor, rsp_stable result bits, their XOR, reliability flags
//   busy                          controller not idle
import oipuf_pkg::*;

module oipuf_eval_ctrl #(
  parameter int TW         = TW_DEF,
  parameter int ST         = ST_DEF,
  parameter int REARM_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int NVOTE      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [ST-1:0] req_chal,
  output logic          puf_tig,
  output logic [ST-1:0] puf_chal,
  input  logic [TW-1:0] puf_resp,
  input  logic [TW-1:0] puf_stable_each,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [TW-1:0] rsp_resp,
  output logic          rsp_xor,
  output logic [TW-1:0] rsp_stable,
  output logic          busy
);

`ifdef MAJORITY_VOTE_EN
  localparam int NEVAL = NVOTE;
`else
  localparam int NEVAL = 1;
`endif
  localparam int CYC_MAX = (REARM_CYC > SETTLE_CYC) ? REARM_CYC : SETTLE_CYC;
  localparam int CW      = oipuf_clog2(CYC_MAX + 1);
  localparam int EW      = oipuf_clog2(NEVAL + 1);

  if (REARM_CYC < 1 || SETTLE_CYC < 1 || NVOTE < 3 || (NVOTE % 2) == 0) begin : g_bad_param
    $error("oipuf_eval_ctrl: illegal REARM_CYC/SETTLE_CYC/NVOTE");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [EW-1:0] eval_q, eval_d;
  logic [ST-1:0] chal_q, chal_d;
  logic          req_ready_q;
  logic          accept;
  logic          sample;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    eval_d  = eval_q;
    chal_d  = chal_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          accept  = 1'b1;
          chal_d  = req_chal;
          eval_d  = '0;
          cyc_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cyc_q == CW'(REARM_CYC - 1)) begin
          cyc_d   = '0;
          state_d = ST_FIRE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_FIRE: begin
        if (cyc_q == CW'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample  = 1'b1;
        eval_d  = eval_q + 1'b1;
        state_d = (eval_q == EW'(NEVAL - 1)) ? ST_DONE : ST_ARM;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      eval_q      <= '0;
      chal_q      <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      eval_q      <= eval_d;
      chal_q      <= chal_d;
      // Registered so req_ready stays low while reset is asserted and rises
      // on the first edge after release.
      req_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign req_ready = req_ready_q;
  assign puf_chal  = chal_q;
  assign puf_tig   = (state_q == ST_FIRE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

`ifdef MAJORITY_VOTE_EN
  for (genvar gi = 0; gi < TW; gi++) begin : g_vote
    oipuf_vote_acc #(
      .NVOTE(NVOTE)
    ) u_vote (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (accept),
      .en_i    (sample),
      .bit_i   (puf_resp[gi]),
      .stable_i(puf_stable_each[gi]),
      .maj_o   (rsp_resp[gi]),
      .rel_o   (rsp_stable[gi])
    );
  end
`else
  logic [TW-1:0] resp_q;
  logic [TW-1:0] stab_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
      stab_q <= '0;
    end else if (accept) begin
      resp_q <= '0;
      stab_q <= '0;
    end else if (sample) begin
      resp_q <= puf_resp;
      stab_q <= puf_stable_each;
    end
  end

  assign rsp_resp   = resp_q;
  assign rsp_stable = stab_q;
`endif

  assign rsp_xor = ^rsp_resp;

endmodule

// File: tb/tb_oipuf_eval_ctrl.sv
// Directed testbench for oipuf_eval_ctrl with a behavioural PUF core model.
module tb_oipuf_eval_ctrl;

  localparam int TW = 4;
  localparam int ST = 64;
  localparam int REARM = 4;
  localparam int SETTLE = 8;
`ifdef MAJORITY_VOTE_EN
  localparam int NEVAL = 5;
`else
  localparam int NEVAL = 1;
`endif
  localparam int E = REARM + SETTLE + 1;

  localparam logic [63:0] C1 = 64'h1444565890ABCDE1;
  localparam logic [63:0] C2 = 64'hDEADBEEF0BADF00D;
  localparam logic [63:0] C3 = 64'h0123456789ABCDEF;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [ST-1:0] req_chal;
  logic          puf_tig;
  logic [ST-1:0] puf_chal;
  logic [TW-1:0] puf_resp;
  logic [TW-1:0] puf_stable_each;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [TW-1:0] rsp_resp;
  logic          rsp_xor;
  logic [TW-1:0] rsp_stable;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  oipuf_eval_ctrl #(
    .TW(TW), .ST(ST), .REARM_CYC(REARM), .SETTLE_CYC(SETTLE), .NVOTE(5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_chal       (req_chal),
    .puf_tig        (puf_tig),
    .puf_chal       (puf_chal),
    .puf_resp       (puf_resp),
    .puf_stable_each(puf_stable_each),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_resp       (rsp_resp),
    .rsp_xor        (rsp_xor),
    .rsp_stable     (rsp_stable),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PUF: one response/stability entry per trigger pulse since the
  // last accept; a wrong challenge inverts the response.
  logic [TW-1:0] resp_seq [8];
  logic [TW-1:0] stab_seq [8];
  logic [ST-1:0] model_chal;
  int            model_idx;
  int            cur_idx;
  logic          tig_d;

  always @(posedge clk) begin
    tig_d <= puf_tig;
    if (req_valid && req_ready) model_idx <= 0;
    else if (puf_tig && !tig_d) model_idx <= model_idx + 1;
  end

  assign cur_idx = (model_idx == 0) ? 0 : ((model_idx > 8) ? 7 : model_idx - 1);
  assign puf_resp = (puf_chal == model_chal) ? resp_seq[cur_idx] : ~resp_seq[cur_idx];
  assign puf_stable_each = stab_seq[cur_idx];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input logic [63:0] chal, input logic [TW-1:0] r, input logic [TW-1:0] s);
    model_chal = chal;
    for (int i = 0; i < 8; i++) begin
      resp_seq[i] = r;
      stab_seq[i] = s;
    end
  endtask

  task automatic start_req(input logic [63:0] chal);
    int w;
    req_chal  = chal;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    check_val("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check_val("accept_busy", busy, 1'b1);
    check_val("accept_chal", puf_chal, chal);
  endtask

  task automatic wait_rsp(input string tag, input logic [TW-1:0] exp_resp, input logic [TW-1:0] exp_stab);
    int lat;
    int tig_cnt;
    lat = 0;
    tig_cnt = 0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
      if (puf_tig) tig_cnt++;
    end
    check_val({tag, "_latency"}, lat, E * NEVAL);
    check_val({tag, "_tig_cycles"}, tig_cnt, SETTLE * NEVAL);
    check_val({tag, "_resp"}, rsp_resp, exp_resp);
    check_val({tag, "_xor"}, rsp_xor, ^exp_resp);
    check_val({tag, "_stable"}, rsp_stable, exp_stab);
    $display("txn %s chal=%h lat=%0d tig=%0d resp=%b xor=%b stable=%b",
             tag, puf_chal, lat, tig_cnt, rsp_resp, rsp_xor, rsp_stable);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val({tag, "_valid_drop"}, rsp_valid, 1'b0);
    check_val({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    logic hold_ok;
    int   drop_idx;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_chal = '0;
    rsp_ready = 1'b0;
    set_model(C1, 4'b0000, 4'b0000);

    // Reset
    #12;
    check_val("rst_req_ready", req_ready, 1'b0);
    check_val("rst_tig", puf_tig, 1'b0);
    check_val("rst_chal", puf_chal, 64'h0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_rsp_resp", rsp_resp, 4'b0000);
    check_val("rst_rsp_stable", rsp_stable, 4'b0000);
    check_val("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("rel_req_ready", req_ready, 1'b1);
    check_val("rel_busy", busy, 1'b0);

    // Single evaluation
    set_model(C1, 4'b1010, 4'b1111);
    start_req(C1);
    wait_rsp("single", 4'b1010, 4'b1111);
    finish_rsp("single");

    // Backpressure with a second request held
    set_model(C2, 4'b0111, 4'b1111);
    start_req(C2);
    wait_rsp("bp", 4'b0111, 4'b1111);
    req_chal  = C3;
    req_valid = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(rsp_valid === 1'b1 && rsp_resp === 4'b0111 && rsp_stable === 4'b1111 &&
            req_ready === 1'b0 && puf_chal === C2 && busy === 1'b1))
        hold_ok = 1'b0;
    end
    check_val("bp_hold", hold_ok, 1'b1);
    set_model(C3, 4'b1100, 4'b1111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("bp_valid_drop", rsp_valid, 1'b0);
    check_val("bp_ready_back", req_ready, 1'b1);
    check_val("bp_chal_kept", puf_chal, C2);
    tick();
    req_valid = 1'b0;
    check_val("bp_second_accept", puf_chal, C3);
    check_val("bp_second_busy", busy, 1'b1);
    wait_rsp("bp2", 4'b1100, 4'b1111);
    finish_rsp("bp2");

    // Stability drop in one sample only
    set_model(C1, 4'b0110, 4'b1111);
    drop_idx = (NEVAL > 1) ? 2 : 0;
    stab_seq[drop_idx] = 4'b1011;
    start_req(C1);
    wait_rsp("stabdrop", 4'b0110, 4'b1011);
    finish_rsp("stabdrop");

`ifdef MAJORITY_VOTE_EN
    // Majority vote: bit0 = 1,1,0,1,0
    set_model(C2, 4'b0000, 4'b1111);
    resp_seq[0] = 4'b0001;
    resp_seq[1] = 4'b0001;
    resp_seq[2] = 4'b0000;
    resp_seq[3] = 4'b0001;
    resp_seq[4] = 4'b0000;
    start_req(C2);
    wait_rsp("vote", 4'b0001, 4'b1110);
    finish_rsp("vote");
`endif

    // Reset in the middle of the trigger window
    set_model(C1, 4'b1010, 4'b1111);
    start_req(C1);
    for (int i = 0; i < 6; i++) tick();
    check_val("midfire_tig", puf_tig, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_tig", puf_tig, 1'b0);
    check_val("midrst_valid", rsp_valid, 1'b0);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ready", req_ready, 1'b0);
    check_val("midrst_chal", puf_chal, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("midrst_rel_ready", req_ready, 1'b1);
    set_model(C2, 4'b0101, 4'b1111);
    start_req(C2);
    wait_rsp("after_rst", 4'b0101, 4'b1111);
    finish_rsp("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
